// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: load-use and hi/lo interlocks,
// multi-cycle MDU sequencing, branch flushes and saturating performance counters.
module pipeline_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mdu_op,
    input  logic             id_reads_hilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        MDU_RUN = 1'b1
    } state_t;

    localparam logic [3:0]       LAT_LOAD = 4'(MDU_LATENCY);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic load_use;
    logic hilo_haz;

    // Index 0 counts stalled cycles, index 1 counts front-end flushes.
    logic [CNT_W-1:0] perf_q [2];
    logic [CNT_W-1:0] perf_d [2];
    logic [1:0]       perf_inc;

    always_comb begin
        load_use = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        hilo_haz = (state_q == MDU_RUN) && (id_mdu_op || id_reads_hilo);
    end

    // Front-end control; a taken branch kills the ID instruction, so its hazards are moot.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mdu_start   = 1'b0;
        mdu_busy    = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            mdu_busy = (state_q == MDU_RUN);
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use || hilo_haz) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                mdu_start = id_mdu_op && (state_q == IDLE);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mdu_start) begin
                    state_d = MDU_RUN;
                    cnt_d   = LAT_LOAD;
                end
            end
            MDU_RUN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        perf_inc[0] = ~pc_write;
        perf_inc[1] = ifid_flush;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            always_comb begin
                perf_d[gi] = perf_q[gi];
                if (perf_inc[gi] && (perf_q[gi] != CNT_MAX)) begin
                    perf_d[gi] = perf_q[gi] + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    perf_q[gi] <= '0;
                end else begin
                    perf_q[gi] <= perf_d[gi];
                end
            end
        end
    endgenerate

    assign stall_cycles = perf_q[0];
    assign flush_count  = perf_q[1];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed and randomized check of pipeline_stall_ctrl against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, id_mdu_op, id_reads_hilo, ex_mem_read, ex_branch_taken;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, mdu_start, mdu_busy;
    logic [CW-1:0] stall_cycles, flush_count;

    int vectors = 0;
    int errs    = 0;

    // Model: busy cycles still owed by the MDU, plus the two counters.
    int rem     = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_mdu_op(id_mdu_op), .id_reads_hilo(id_reads_hilo),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic mdu_op, input logic rd_hilo,
                        input logic mem_rd, input logic [4:0] ert, input logic br);
        logic busy, lu, hh, e_pc, e_ifw, e_fl, e_bub, e_st;
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
        id_mdu_op = mdu_op; id_reads_hilo = rd_hilo; ex_mem_read = mem_rd;
        ex_rt = ert; ex_branch_taken = br;
        @(negedge clk);
        busy = (rem > 0);
        lu   = mem_rd && (ert != 0) && ((ert == rs) || (uses_rt && (ert == rt)));
        hh   = busy && (mdu_op || rd_hilo);
        e_st = 1'b0;
        if (rst) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1; busy = 0;
        end else if (br) begin
            e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
        end else if (lu || hh) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
            e_st = mdu_op && !busy;
        end
        check("pc_write", pc_write, e_pc);
        check("ifid_write", ifid_write, e_ifw);
        check("ifid_flush", ifid_flush, e_fl);
        check("idex_bubble", idex_bubble, e_bub);
        check("mdu_start", mdu_start, e_st);
        check("mdu_busy", mdu_busy, busy);
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
        if (rst) begin
            rem = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX) m_flush++;
            if (rem > 0) rem--;
            else if (e_st) rem = LAT;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(0, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 0);
    endtask

    initial begin
        reset = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_mdu_op = 0;
        id_reads_hilo = 0; ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, 5'd3, 0);

        // lw $5 then add using $5: one-cycle stall, then the bubble clears the load
        step(0, 5'd5, 5'd9, 1, 0, 0, 1, 5'd5, 0);
        step(0, 5'd5, 5'd9, 1, 0, 0, 0, 5'd0, 0);
        check("t1_stall_count", stall_cycles, 1);

        // $0 destination and unused rt never stall
        step(0, 5'd0, 5'd4, 1, 0, 0, 1, 5'd0, 0);
        step(0, 5'd2, 5'd7, 0, 0, 0, 1, 5'd7, 0);
        check("t2_stall_count", stall_cycles, 1);

        // mult then mflo: stalled for the four busy cycles
        step(0, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, 0);
        for (int i = 0; i < LAT; i++) step(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
        check("t3_stall_count", stall_cycles, 1 + LAT);

        // load-use coinciding with a taken branch: flush wins
        step(0, 5'd3, 5'd0, 0, 0, 0, 1, 5'd3, 1);
        check("t4_flush_count", flush_count, 1);
        check("t4_stall_count", stall_cycles, 1 + LAT);

        // back-to-back mult, with a branch during the run
        step(0, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, 0);
        for (int i = 0; i < LAT; i++) step(0, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, (i == 1));
        for (int i = 0; i < LAT + 1; i++) nop();

        // reset in the middle of an MDU op, then an immediate reissue
        step(0, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, 0);
        nop();
        step(1, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, 0);
        check("t6_busy_after_reset", mdu_busy, 0);
        check("t6_stall_after_reset", stall_cycles, 0);
        step(0, 5'd8, 5'd9, 1, 1, 0, 0, 5'd0, 0);
        check("t6_busy_reissue", mdu_busy, 1);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
